// File: rtl/shiftreg_seq_ctrl.sv
// Command sequencer that serialises a byte into an 8-bit bidirectional shift register
// and tracks the register contents in q_model. Optional stall input via SHIFTREG_SEQ_PAUSE_EN.
module shiftreg_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_len,
   output logic             sl,
   output logic             sr,
   output logic             din,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] shift_cnt,
   output logic [WIDTH-1:0] q_model
`ifdef SHIFTREG_SEQ_PAUSE_EN
   ,
   input  logic             pause
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic             dir_r, dir_n;
   logic [WIDTH-1:0] dsh, dsh_n;
   logic             sl_n, sr_n, din_n, busy_n, done_n;
   logic [CNT_W-1:0] cnt_n;
   logic [WIDTH-1:0] q_n;
   logic             stall;
   logic             shifted;

`ifdef SHIFTREG_SEQ_PAUSE_EN
   assign stall = pause;
`else
   assign stall = 1'b0;
`endif

   // A bit is consumed by the register on every edge where the registered enables are high.
   assign shifted = sl | sr;

   function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
      if (len == '0 || len > CNT_W'(WIDTH))
         return CNT_W'(WIDTH);
      else
         return len;
   endfunction

   always_comb begin
      state_n = state;
      dir_n   = dir_r;
      dsh_n   = dsh;
      sl_n    = sl;
      sr_n    = sr;
      din_n   = din;
      busy_n  = busy;
      done_n  = 1'b0;
      cnt_n   = shift_cnt;
      unique case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            sl_n    = 1'b0;
            sr_n    = 1'b0;
            din_n   = 1'b0;
            busy_n  = 1'b0;
            cnt_n   = '0;
            if (start && !abort) begin
               state_n = SHIFT;
               dir_n   = cmd_dir;
               busy_n  = 1'b1;
               cnt_n   = eff_len(cmd_len);
               sl_n    = ~cmd_dir;
               sr_n    = cmd_dir;
               // First bit goes out now; dsh holds the remaining bits pre-aligned.
               if (cmd_dir) begin
                  din_n = cmd_data[0];
                  dsh_n = cmd_data >> 1;
               end else begin
                  din_n = cmd_data[WIDTH-1];
                  dsh_n = cmd_data << 1;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               state_n = IDLE;
               sl_n    = 1'b0;
               sr_n    = 1'b0;
               din_n   = 1'b0;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end else if (shifted && shift_cnt == CNT_W'(1)) begin
               state_n = DONE;
               sl_n    = 1'b0;
               sr_n    = 1'b0;
               din_n   = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               cnt_n   = '0;
            end else begin
               if (shifted) begin
                  cnt_n = shift_cnt - CNT_W'(1);
                  din_n = dir_r ? dsh[0] : dsh[WIDTH-1];
                  dsh_n = dir_r ? (dsh >> 1) : (dsh << 1);
               end
               sl_n = ~stall & ~dir_r;
               sr_n = ~stall & dir_r;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_comb begin
      q_n = q_model;
      if (sl)
         q_n = {q_model[WIDTH-2:0], din};
      else if (sr)
         q_n = {din, q_model[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dir_r     <= 1'b0;
         dsh       <= '0;
         sl        <= 1'b0;
         sr        <= 1'b0;
         din       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         shift_cnt <= '0;
         q_model   <= '0;
      end else begin
         state     <= state_n;
         dir_r     <= dir_n;
         dsh       <= dsh_n;
         sl        <= sl_n;
         sr        <= sr_n;
         din       <= din_n;
         busy      <= busy_n;
         done      <= done_n;
         shift_cnt <= cnt_n;
         q_model   <= q_n;
      end
   end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Directed bench for shiftreg_seq_ctrl: table of commands plus hand-written abort,
// back-to-back, async-reset and (with SHIFTREG_SEQ_PAUSE_EN) pause sequences.
module tb_shiftreg_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic       cmd_dir;
   logic [7:0] cmd_data;
   logic [3:0] cmd_len;
   logic       sl, sr, din, busy, done;
   logic [3:0] shift_cnt;
   logic [7:0] q_model;
   logic       pause;

   int total = 0;
   int bad   = 0;

   shiftreg_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cmd_dir(cmd_dir), .cmd_data(cmd_data), .cmd_len(cmd_len),
      .sl(sl), .sr(sr), .din(din), .busy(busy), .done(done),
      .shift_cnt(shift_cnt), .q_model(q_model)
`ifdef SHIFTREG_SEQ_PAUSE_EN
      , .pause(pause)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the physical shift register and edge counters.
   logic [7:0] qreg;
   int n_sl = 0, n_sr = 0, n_busy = 0, n_done = 0, n_both = 0;

   always @(posedge clk or posedge reset) begin
      if (reset)   qreg <= 8'h00;
      else if (sl) qreg <= {qreg[6:0], din};
      else if (sr) qreg <= {din, qreg[7:1]};
   end

   always @(posedge clk) begin
      if (sl)        n_sl   <= n_sl + 1;
      if (sr)        n_sr   <= n_sr + 1;
      if (busy)      n_busy <= n_busy + 1;
      if (done)      n_done <= n_done + 1;
      if (sl && sr)  n_both <= n_both + 1;
   end

   typedef struct {
      logic       dir;
      logic [7:0] data;
      logic [3:0] len;
      logic [7:0] exp_q;
      int         exp_n;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input string name);
      int got;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check({name, "_done_seen"}, got, 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int s0, r0, b0, d0;
      string nm;
      nm = $sformatf("v%0d", idx);
      @(negedge clk);
      s0 = n_sl; r0 = n_sr; b0 = n_busy; d0 = n_done;
      cmd_dir = v.dir; cmd_data = v.data; cmd_len = v.len; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({nm, "_cnt0"}, shift_cnt, v.exp_n);
      check({nm, "_busy0"}, busy, 1);
      wait_done(nm);
      check({nm, "_qmodel"}, q_model, v.exp_q);
      check({nm, "_qreg"}, qreg, v.exp_q);
      check({nm, "_nsl"}, n_sl - s0, v.dir ? 0 : v.exp_n);
      check({nm, "_nsr"}, n_sr - r0, v.dir ? v.exp_n : 0);
      check({nm, "_nbusy"}, n_busy - b0, v.exp_n);
      @(negedge clk);
      check({nm, "_done1cyc"}, n_done - d0, 1);
      check({nm, "_idle"}, {done, busy, sl, sr}, 4'b0000);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
      cmd_dir = 1'b0; cmd_data = 8'h00; cmd_len = 4'd0;

      // dir, data, len, expected Q (chained from previous), expected shift count
      tbl[0] = '{1'b0, 8'hA5, 4'd0,  8'hA5, 8};
      tbl[1] = '{1'b1, 8'h3C, 4'd0,  8'h3C, 8};
      tbl[2] = '{1'b0, 8'hFF, 4'd0,  8'hFF, 8};
      tbl[3] = '{1'b0, 8'h80, 4'd3,  8'hFC, 3};
      tbl[4] = '{1'b1, 8'h01, 4'd1,  8'hFE, 1};
      tbl[5] = '{1'b0, 8'h5A, 4'd15, 8'h5A, 8};
      tbl[6] = '{1'b1, 8'hF0, 4'd4,  8'h05, 4};
      tbl[7] = '{1'b0, 8'hC3, 4'd9,  8'hC3, 8};

      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_state", {sl, sr, din, busy, done, shift_cnt, q_model}, 17'h0);

      for (int i = 0; i < 8; i++) run_vec(tbl[i], i);
      check("never_both", n_both, 0);

      // shift_cnt trace for a 3-bit left command from a cleared register
      do_reset();
      cmd_dir = 1'b0; cmd_data = 8'h80; cmd_len = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("trace_c3", shift_cnt, 3);
      @(negedge clk);
      check("trace_c2", shift_cnt, 2);
      @(negedge clk);
      check("trace_c1", shift_cnt, 1);
      @(negedge clk);
      check("trace_c0", {done, shift_cnt}, 5'b1_0000);
      check("trace_q", q_model, 8'h04);

      // abort during the 4th shift of a right load of 0F, with start also high
      begin
         int d0, r0;
         do_reset();
         d0 = n_done; r0 = n_sr;
         cmd_dir = 1'b1; cmd_data = 8'h0F; cmd_len = 4'd0; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (3) @(negedge clk);
         abort = 1'b1; start = 1'b1; cmd_data = 8'h55;
         @(negedge clk);
         abort = 1'b0; start = 1'b0;
         check("abort_idle", {busy, sl, sr, shift_cnt}, 7'h0);
         check("abort_qmodel", q_model, 8'hF0);
         check("abort_qreg", qreg, 8'hF0);
         check("abort_nsr", n_sr - r0, 4);
         repeat (4) @(negedge clk);
         check("abort_no_done", n_done - d0, 0);
         check("abort_stays_idle", {busy, sl, sr}, 3'b000);
         // abort and start together in IDLE: abort wins
         start = 1'b1; abort = 1'b1;
         @(negedge clk);
         start = 1'b0; abort = 1'b0;
         check("abort_start_idle", {busy, sl, sr}, 3'b000);
      end

      // back-to-back: start held through first SHIFT and DONE
      begin
         int s0;
         do_reset();
         s0 = n_sl;
         cmd_dir = 1'b0; cmd_data = 8'hC0; cmd_len = 4'd2; start = 1'b1;
         @(negedge clk);
         cmd_dir = 1'b1; cmd_data = 8'h0A; cmd_len = 4'd4;
         wait_done("b2b_first");
         check("b2b_first_nsl", n_sl - s0, 2);
         check("b2b_first_q", q_model, 8'h03);
         @(negedge clk);
         start = 1'b0;
         check("b2b_second_entry", {busy, done, sr, sl, shift_cnt}, 8'b1010_0100);
         wait_done("b2b_second");
         check("b2b_second_q", q_model, 8'hA0);
         check("b2b_second_qreg", qreg, 8'hA0);
      end

      // asynchronous reset between clock edges in the middle of a command
      begin
         int d0;
         do_reset();
         cmd_dir = 1'b0; cmd_data = 8'hA5; cmd_len = 4'd0; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         check("arst_pre_q", q_model, 8'h01);
         #2 reset = 1'b1;
         #1;
         check("arst_now", {sl, sr, din, busy, done, shift_cnt, q_model}, 17'h0);
         #1 reset = 1'b0;
         d0 = n_done;
         repeat (4) @(negedge clk);
         check("arst_no_done", n_done - d0, 0);
         check("arst_idle", {busy, sl, sr}, 3'b000);
      end

`ifdef SHIFTREG_SEQ_PAUSE_EN
      begin
         int r0;
         do_reset();
         r0 = n_sr;
         cmd_dir = 1'b1; cmd_data = 8'h3C; cmd_len = 4'd0; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (2) @(negedge clk);
         pause = 1'b1;
         repeat (5) @(negedge clk);
         check("pause_stalled", {busy, sr, sl}, 3'b100);
         pause = 1'b0;
         wait_done("pause");
         check("pause_nsr", n_sr - r0, 8);
         check("pause_q", q_model, 8'h3C);
         check("pause_qreg", qreg, 8'h3C);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
